// File: rtl/transpose_job_arbiter.sv
// transpose_job_arbiter: shares one 3x3 transpose engine between two
// requesters round-robin, streams loads, forwards results, flags errors.
module transpose_job_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MAT_SIZE   = 9,
   parameter int TIMEOUT    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic [DATA_WIDTH-1:0] eng_a_in,
   output logic [3:0]            eng_a_addr,
   output logic                  eng_a_wen,
   output logic                  eng_start,
   input  logic [DATA_WIDTH-1:0] eng_c_out,
   input  logic                  eng_c_valid,
   input  logic                  eng_done,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [3:0]            rsp_index,
   output logic                  rsp_last,
   output logic                  job_done,
   output logic                  job_err,
   output logic                  busy
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0]    LAST     = 4'(MAT_SIZE - 1);
   localparam logic [3:0]    FULL     = 4'(MAT_SIZE);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      RUN,
      FIN
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [3:0]            load_cnt;
   logic [3:0]            out_cnt;
   logic [3:0]            out_cnt_nxt;
   logic [TW-1:0]         tmo_cnt;
   logic                  grant;
   logic                  grant_nxt;
   logic                  last_grant;
   logic                  err;
   logic                  any_req;
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  load_hs;
   logic                  res_acc;
   logic                  tmo_hit;

   // arbitration pick, granted-requester mux and datapath qualifiers
   always_comb begin
      any_req   = req0_valid | req1_valid;
      grant_nxt = 1'b0;
      unique case (1'b1)
         (req0_valid && req1_valid): grant_nxt = ~last_grant;
         (req1_valid && !req0_valid): grant_nxt = 1'b1;
         default: grant_nxt = 1'b0;
      endcase
      sel_valid   = grant ? req1_valid : req0_valid;
      sel_data    = grant ? req1_data : req0_data;
      load_hs     = (state == LOAD) && sel_valid;
      res_acc     = (state == RUN) && eng_c_valid && (out_cnt < FULL);
      out_cnt_nxt = out_cnt + {3'b000, res_acc};
      tmo_hit     = (tmo_cnt == TMO_LAST);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (any_req) state_nxt = LOAD;
         LOAD:  if (load_hs && load_cnt == LAST) state_nxt = START;
         START: state_nxt = RUN;
         RUN:   if (eng_done || tmo_hit) state_nxt = FIN;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-derived handshakes, engine load port and job status
   always_comb begin
      req0_ready = (state == LOAD) && !grant;
      req1_ready = (state == LOAD) && grant;
      eng_a_wen  = load_hs;
      eng_a_addr = load_cnt;
      eng_a_in   = (state == LOAD) ? sel_data : '0;
      eng_start  = (state == START);
      job_done   = (state == FIN);
      job_err    = (state == FIN) && err;
      busy       = (state != IDLE);
   end

   // job bookkeeping: grant, counters and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         load_cnt   <= '0;
         out_cnt    <= '0;
         tmo_cnt    <= '0;
         err        <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            grant    <= grant_nxt;
            load_cnt <= '0;
         end
         if (load_hs) begin
            load_cnt <= load_cnt + 4'd1;
         end
         if (state == START) begin
            out_cnt <= '0;
            tmo_cnt <= '0;
         end
         if (state == RUN) begin
            out_cnt <= out_cnt_nxt;
            tmo_cnt <= tmo_cnt + TW'(1);
            if (eng_c_valid && !res_acc) begin
               err <= 1'b1;
            end
            if (eng_done) begin
               if (out_cnt_nxt != FULL) err <= 1'b1;
            end else if (tmo_hit) begin
               err <= 1'b1;
            end
         end
         if (state == FIN) begin
            last_grant <= grant;
            err        <= 1'b0;
         end
      end
   end

   // registered result forwarding, tagged with the owning requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         rsp_index <= '0;
         rsp_last  <= 1'b0;
      end else begin
         rsp_valid <= res_acc;
         rsp_last  <= res_acc && (out_cnt == LAST);
         if (state == START) begin
            rsp_id <= grant;
         end
         if (res_acc) begin
            rsp_data  <= eng_c_out;
            rsp_index <= out_cnt;
            rsp_id    <= grant;
         end
      end
   end

endmodule

// File: tb/tb_transpose_job_arbiter.sv
// tb_transpose_job_arbiter: random jobs from two requesters against a
// job-level model of arbitration, transpose results and error outcomes.
module tb_transpose_job_arbiter;

   localparam int DW  = 32;
   localparam int MS  = 9;
   localparam int TMO = 32;

   typedef enum int {M_OK, M_SHORT, M_EXTRA, M_NODONE} mode_t;

   typedef struct {
      int          id;
      logic [DW-1:0] w [9];
      mode_t       mode;
   } job_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rv [2];
   logic [DW-1:0] rd [2];
   logic          req0_ready, req1_ready;
   logic [DW-1:0] eng_a_in;
   logic [3:0]    eng_a_addr;
   logic          eng_a_wen, eng_start;
   logic [DW-1:0] eng_c_out;
   logic          eng_c_valid, eng_done;
   logic [DW-1:0] rsp_data;
   logic          rsp_valid, rsp_id;
   logic [3:0]    rsp_index;
   logic          rsp_last, job_done, job_err, busy;

   int            checks = 0;
   int            errors = 0;
   job_t          job_q [$];
   logic [DW-1:0] rsp_log [$];
   int            done_log [$];
   logic [DW-1:0] mem [16];
   bit            model_lg = 1'b1;
   bit            hung = 1'b0;

   transpose_job_arbiter #(
      .DATA_WIDTH(DW),
      .MAT_SIZE(MS),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req0_valid(rv[0]),
      .req0_data(rd[0]),
      .req0_ready(req0_ready),
      .req1_valid(rv[1]),
      .req1_data(rd[1]),
      .req1_ready(req1_ready),
      .eng_a_in(eng_a_in),
      .eng_a_addr(eng_a_addr),
      .eng_a_wen(eng_a_wen),
      .eng_start(eng_start),
      .eng_c_out(eng_c_out),
      .eng_c_valid(eng_c_valid),
      .eng_done(eng_done),
      .rsp_data(rsp_data),
      .rsp_valid(rsp_valid),
      .rsp_id(rsp_id),
      .rsp_index(rsp_index),
      .rsp_last(rsp_last),
      .job_done(job_done),
      .job_err(job_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int exp_cnt(input mode_t m);
      return (m == M_SHORT) ? 8 : 9;
   endfunction

   // C = A^T in row-major order: C[r][c] = A[c][r]
   function automatic logic [DW-1:0] tr(input job_t j, input int idx);
      return j.w[(idx % 3) * 3 + idx / 3];
   endfunction

   task automatic check_quiet(input string tag);
      chk_eq({tag, "_busy"}, busy, 0);
      chk_eq({tag, "_eng_start"}, eng_start, 0);
      chk_eq({tag, "_eng_a_wen"}, eng_a_wen, 0);
      chk_eq({tag, "_eng_a_addr"}, eng_a_addr, 0);
      chk_eq({tag, "_eng_a_in"}, eng_a_in, 0);
      chk_eq({tag, "_ready"}, {req1_ready, req0_ready}, 0);
      chk_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      chk_eq({tag, "_rsp_data"}, rsp_data, 0);
      chk_eq({tag, "_rsp_id"}, rsp_id, 0);
      chk_eq({tag, "_rsp_index"}, rsp_index, 0);
      chk_eq({tag, "_rsp_last"}, rsp_last, 0);
      chk_eq({tag, "_job_done"}, job_done, 0);
      chk_eq({tag, "_job_err"}, job_err, 0);
   endtask

   // compare process: every DUT event is matched to the front job
   initial begin : cmp
      int  wr_idx, rsp_idx, cyc, start_cyc, m_cnt;
      bit  in_rst;
      wr_idx = 0; rsp_idx = 0; cyc = 0; start_cyc = 0; in_rst = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            if (!in_rst && job_q.size() > 0) void'(job_q.pop_front());
            in_rst = 1'b1;
            wr_idx = 0;
            rsp_idx = 0;
         end else begin
            in_rst = 1'b0;
            if (req0_ready || req1_ready) begin
               chk_eq("ready_owner", {req1_ready, req0_ready},
                      job_q.size() == 0 ? 2'b00 :
                      (job_q[0].id == 1 ? 2'b10 : 2'b01));
            end
            if (eng_a_wen) begin
               mem[eng_a_addr] = eng_a_in;
               if (job_q.size() == 0 || wr_idx >= MS) begin
                  chk_eq("extra_write", wr_idx, MS - 1);
               end else begin
                  chk_eq("wr_addr", eng_a_addr, wr_idx);
                  chk_eq("wr_data", eng_a_in, job_q[0].w[wr_idx]);
               end
               wr_idx++;
            end
            if (eng_start) begin
               chk_eq("start_after_load", wr_idx, MS);
               start_cyc = cyc;
            end
            if (rsp_valid) begin
               m_cnt = (job_q.size() > 0) ? exp_cnt(job_q[0].mode) : 0;
               if (rsp_idx >= m_cnt) begin
                  chk_eq("extra_rsp", rsp_idx, m_cnt - 1);
               end else begin
                  chk_eq("rsp_id", rsp_id, job_q[0].id);
                  chk_eq("rsp_index", rsp_index, rsp_idx);
                  chk_eq("rsp_data", rsp_data, tr(job_q[0], rsp_idx));
                  chk_eq("rsp_last", rsp_last, rsp_idx == MS - 1);
               end
               rsp_log.push_back(rsp_data);
               rsp_idx++;
            end
            if (job_done) begin
               if (job_q.size() == 0) begin
                  chk_eq("unexpected_done", job_done, 0);
               end else begin
                  chk_eq("done_id", rsp_id, job_q[0].id);
                  chk_eq("done_err", job_err, job_q[0].mode != M_OK);
                  chk_eq("rsp_count", rsp_idx, exp_cnt(job_q[0].mode));
                  if (job_q[0].mode == M_NODONE) begin
                     chk_eq("tmo_delay", cyc - start_cyc, TMO + 1);
                  end
                  done_log.push_back(job_q[0].id);
                  void'(job_q.pop_front());
               end
               wr_idx = 0;
               rsp_idx = 0;
            end
         end
      end
   end

   task automatic eng_tick(inout bit dead);
      @(posedge clk);
      #1;
      if (!rst_n) dead = 1'b1;
   endtask

   // engine model: transposes what was written to its load port
   task automatic run_engine(input mode_t m);
      int n, lat;
      bit co, dead;
      dead = 1'b0;
      n = (m == M_SHORT) ? 8 : (m == M_EXTRA) ? 10 : 9;
      co = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      eng_tick(dead);
      for (int i = 0; i < lat && !dead; i++) eng_tick(dead);
      for (int k = 0; k < n && !dead; k++) begin
         eng_c_valid = 1'b1;
         eng_c_out = (k < 9) ? mem[(k % 3) * 3 + k / 3] : $urandom;
         eng_done = (k == n - 1) && co && (m != M_NODONE);
         eng_tick(dead);
         eng_c_valid = 1'b0;
         eng_done = 1'b0;
         eng_c_out = '0;
         if (!dead && m != M_NODONE && $urandom_range(0, 2) == 0)
            eng_tick(dead);
      end
      if (!dead && !co && m != M_NODONE) begin
         lat = $urandom_range(0, 2);
         for (int i = 0; i < lat && !dead; i++) eng_tick(dead);
         if (!dead) begin
            eng_done = 1'b1;
            eng_tick(dead);
            eng_done = 1'b0;
         end
      end
   endtask

   initial begin : eng
      eng_c_valid = 1'b0;
      eng_done = 1'b0;
      eng_c_out = '0;
      forever begin
         @(negedge clk);
         if (rst_n && eng_start)
            run_engine(job_q.size() > 0 ? job_q[0].mode : M_OK);
      end
   end

   // requester: holds valid until first accept, then may insert gaps
   task automatic drive_req(input job_t j, input int gap);
      int  k, wait_c, id;
      bit  started, hs;
      id = j.id; k = 0; wait_c = 0; started = 1'b0;
      rv[id] = 1'b1;
      rd[id] = j.w[0];
      while (k < MS) begin
         @(negedge clk);
         hs = rv[id] && ((id == 0) ? req0_ready : req1_ready);
         @(posedge clk);
         #1;
         if (hs) begin
            k++;
            started = 1'b1;
            wait_c = 0;
         end else begin
            wait_c++;
         end
         if (wait_c > 500) begin
            chk_eq("req_accept_bound", k, MS);
            break;
         end
         if (k < MS) begin
            if (started && $urandom_range(0, 99) < gap) begin
               rv[id] = 1'b0;
               rd[id] = $urandom;
            end else begin
               rv[id] = 1'b1;
               rd[id] = j.w[k];
            end
         end
      end
      rv[id] = 1'b0;
      rd[id] = '0;
   endtask

   task automatic make_job(output job_t j, input int id, input mode_t m,
                           input bit seq);
      j.id = id;
      j.mode = m;
      for (int i = 0; i < MS; i++)
         j.w[i] = seq ? DW'(id * 10 + i + 1) : $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (job_q.size() > 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (job_q.size() > 0) begin
         chk_eq("job_drain_bound", job_q.size(), 0);
         hung = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // one round: model orders the jobs round-robin, then both drive
   task automatic run_round(input bit u0, input bit u1, input int gap,
                            input mode_t m0, input mode_t m1,
                            input bit seq);
      job_t j0, j1;
      bit   first;
      make_job(j0, 0, m0, seq);
      make_job(j1, 1, m1, seq);
      first = (u0 && u1) ? ~model_lg : u1;
      if (first) begin
         if (u1) job_q.push_back(j1);
         if (u0) job_q.push_back(j0);
         model_lg = u0 ? 1'b0 : 1'b1;
      end else begin
         if (u0) job_q.push_back(j0);
         if (u1) job_q.push_back(j1);
         model_lg = u1 ? 1'b1 : 1'b0;
      end
      fork
         begin if (u0) drive_req(j0, gap); end
         begin if (u1) drive_req(j1, gap); end
      join
      drain();
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   lit [9];
      int   base, dbase, r, n;
      bit   u0, u1;
      job_t jr;
      mode_t rm [2];
      lit = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
      rv[0] = 1'b0; rv[1] = 1'b0;
      rd[0] = '0; rd[1] = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      base = rsp_log.size();
      dbase = done_log.size();
      run_round(1, 1, 0, M_OK, M_OK, 1);
      for (int i = 0; i < MS; i++) begin
         chk_eq("first_job_rsp", rsp_log.size() > base + i ?
                rsp_log[base + i] : 64'hx, lit[i]);
      end
      if (!hung) run_round(1, 1, 0, M_OK, M_OK, 1);
      if (!hung) run_round(1, 0, 0, M_OK, M_OK, 1);
      for (int i = 0; i < 5; i++) begin
         chk_eq("contention_order", done_log.size() > dbase + i ?
                done_log[dbase + i] : -1, (i == 4) ? 0 : i % 2);
      end

      if (!hung) run_round(0, 1, 50, M_OK, M_OK, 0);
      if (!hung) run_round(1, 0, 0, M_SHORT, M_OK, 0);
      if (!hung) run_round(0, 1, 0, M_OK, M_NODONE, 0);
      if (!hung) run_round(1, 0, 20, M_EXTRA, M_OK, 0);

      for (int i = 0; i < 40 && !hung; i++) begin
         r = $urandom_range(1, 3);
         u0 = r[0];
         u1 = r[1];
         for (int k = 0; k < 2; k++) begin
            n = $urandom_range(0, 9);
            rm[k] = (n == 0) ? M_SHORT : (n == 1) ? M_EXTRA :
                    (n == 2) ? M_NODONE : M_OK;
         end
         run_round(u0, u1, $urandom_range(0, 60), rm[0], rm[1], 0);
      end

      if (!hung) begin
         make_job(jr, 1, M_OK, 0);
         job_q.push_back(jr);
         drive_req(jr, 0);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!eng_start && n < 50);
         chk_eq("mid_reset_start_seen", eng_start, 1);
         repeat (3) @(posedge clk);
         #3 rst_n = 1'b0;
         #1;
         check_quiet("mid_reset");
         @(posedge clk);
         #3 rst_n = 1'b1;
         model_lg = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         chk_eq("mid_reset_abandon", job_q.size(), 0);
         dbase = done_log.size();
         run_round(1, 1, 0, M_OK, M_OK, 0);
         for (int i = 0; i < 2; i++) begin
            chk_eq("post_reset_order", done_log.size() > dbase + i ?
                   done_log[dbase + i] : -1, i);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/transpose_job_arbiter.md
Name: transpose_job_arbiter

Overview:
- Front-end controller that shares one 3x3 transpose engine between two requesters.
- Grants one requester at a time (round-robin) and streams that requester's 9 matrix words into the engine's load port (addresses 0..8).
- Pulses the engine's start, then forwards the 9 engine results back, tagged with the requester id.
- Flags protocol errors (wrong result count, missing done, timeout).

Parameters:
DATA_WIDTH, 32, width of matrix elements (signed)
MAT_SIZE, 9, words per job; engine address width is 4 bits
TIMEOUT, 32, max cycles in RUN waiting for eng_done before abort

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 offers a load word
req0_data  in  DATA_WIDTH  requester 0 load word (row-major order)
req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
req1_valid  in  1  requester 1 offers a load word
req1_data  in  DATA_WIDTH  requester 1 load word
req1_ready  out  1  requester 1 word accepted
eng_a_in  out  DATA_WIDTH  engine load data
eng_a_addr  out  4  engine load address
eng_a_wen  out  1  engine load write enable
eng_start  out  1  one-cycle engine start pulse
eng_c_out  in  DATA_WIDTH  engine result
eng_c_valid  in  1  engine result valid
eng_done  in  1  engine job-complete pulse
rsp_data  out  DATA_WIDTH  forwarded result
rsp_valid  out  1  forwarded result valid (no backpressure)
rsp_id  out  1  requester owning rsp/job_done
rsp_index  out  4  flat index 0..8 of rsp_data
rsp_last  out  1  high with the 9th result
job_done  out  1  one-cycle job completion pulse
job_err  out  1  qualifies job_done: job ended abnormally
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, load_cnt=0, out_cnt=0, tmo_cnt=0, grant=0, last_grant=1 (so req0 wins first).
- Reset values of registered outputs: eng_start=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_index=0, rsp_last=0, job_done=0, job_err=0.
- Reset mid-job abandons the job silently; no job_done is issued.
- States: IDLE, LOAD, START, RUN, FIN.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - On grant: load_cnt=0 and go to LOAD next cycle.
  - Requests are not sampled in any other state.
- LOAD:
  - reqX_ready = (state==LOAD && grant==X), combinational; the non-granted requester sees ready=0.
  - eng_a_wen = granted valid & ready; eng_a_addr = load_cnt; eng_a_in = granted data. All three are combinational pass-through, zero latency.
  - Each handshake increments load_cnt.
  - The handshake with load_cnt==MAT_SIZE-1 moves to START.
  - Valid gaps stall LOAD indefinitely; there is no timeout in LOAD.
- START: eng_start=1 for exactly one cycle; out_cnt=0, tmo_cnt=0; go to RUN.
- RUN:
  - Each eng_c_valid registers to the rsp_* outputs one cycle later: rsp_valid=1, rsp_data=eng_c_out, rsp_index=out_cnt, rsp_id=grant, rsp_last=(out_cnt==MAT_SIZE-1).
  - out_cnt increments and saturates at MAT_SIZE.
  - eng_c_valid after out_cnt has reached MAT_SIZE: the word is dropped and an error is recorded.
  - eng_done (also when coincident with eng_c_valid; that word is still forwarded) moves to FIN. Error is recorded if the final out_cnt != MAT_SIZE.
  - tmo_cnt increments every RUN cycle. Reaching TIMEOUT-1 without eng_done moves to FIN with error.
- FIN (one cycle):
  - job_done=1, job_err=recorded error, rsp_id=grant.
  - last_grant=grant; clear the error flag; go to IDLE.
- Throughput: 9 load cycles + 1 IDLE + 1 START + engine run + 1 FIN per job.
- A requester may re-request immediately after job_done. If the other requester is waiting, the other is served first.

Test Plan:
- Single job: req0 streams 1..9 with no gaps → eng_a_addr 0..8, one eng_start pulse. With a behavioural engine model, rsp_data = 1,4,7,2,5,8,3,6,9 with rsp_index 0..8, rsp_id=0, rsp_last on the 9th word, then job_done=1, job_err=0.
- Contention: both valid in the same IDLE cycle after reset → req0 served first, then req1. Then both valid again → req0 served, because last_grant=1 after the req1 job.
- Load gaps: req1_valid toggles every other cycle → exactly 9 writes, eng_start only after the 9th, req0_ready stays 0 throughout.
- Engine fault: model emits only 8 eng_c_valid then eng_done → job_done=1 with job_err=1, return to IDLE.
- Timeout: model never asserts eng_done → job_done and job_err both 1 exactly TIMEOUT cycles after entering RUN.
- Reset mid-RUN: rst_n low for 1 cycle → all outputs 0 immediately (async), no job_done. The next request is served with req0 priority.
